// File: rtl/ux607_mrom_pkg.sv
// Shared definitions for the MROM ICB pipeline: byte-offset width helper and
// the response entry layout held in the response buffer.
package ux607_mrom_pkg;

    localparam int unsigned MROM_DW = 32;

    typedef struct packed {
        logic               err;
        logic [MROM_DW-1:0] rdata;
    } mrom_rsp_t;

    function automatic int unsigned mrom_ob(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/ux607_mrom.sv
// Read-only word array; each word holds a fixed tag in the upper half and its
// own index in the lower half. Purely combinational read.
module ux607_mrom #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic [AW-1:0] rom_addr,
    output logic [DW-1:0] rom_dout
);

    assign rom_dout = DW'({16'hA5A5, 16'(rom_addr)});

endmodule

// File: rtl/ux607_mrom_rsp_fifo.sv
// In-order response buffer with occupancy counter; depth need not be a power
// of two. Head output reads as zero whenever the buffer is empty.
module ux607_mrom_rsp_fifo #(
    parameter int unsigned W     = 33,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_nonempty,
    output logic [W-1:0] o_head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_mem [DEPTH];
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_rd_nxt;

    assign w_push   = i_push && (r_cnt < CW'(DEPTH));
    assign w_pop    = i_pop && (r_cnt != {CW{1'b0}});
    // explicit wrap compare keeps non-power-of-two depths correct
    assign w_wr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : r_wr_ptr + 1'b1;
    assign w_rd_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : r_rd_ptr + 1'b1;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_cnt    <= {CW{1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= w_wr_nxt;
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_full     = (r_cnt == CW'(DEPTH));
    assign o_nonempty = (r_cnt != {CW{1'b0}});
    assign o_head     = o_nonempty ? r_mem[r_rd_ptr] : {W{1'b0}};

endmodule

// File: rtl/ux607_mrom_pipe_top.sv
// ICB front-end for the MROM: decodes/validates each accepted command, reads
// the ROM at accept time and queues {err, rdata} for in-order return.
module ux607_mrom_pipe_top
    import ux607_mrom_pkg::*;
#(
    parameter int unsigned AW        = 12,
    parameter int unsigned DW        = 32,
    parameter int unsigned DP        = 1024,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rom_icb_cmd_valid,
    output logic          rom_icb_cmd_ready,
    input  logic [AW-1:0] rom_icb_cmd_addr,
    input  logic          rom_icb_cmd_read,
    output logic          rom_icb_rsp_valid,
    input  logic          rom_icb_rsp_ready,
    output logic          rom_icb_rsp_err,
    output logic [DW-1:0] rom_icb_rsp_rdata,
    output logic          rom_busy
);

    localparam int unsigned OB = mrom_ob(DW);
    localparam int unsigned IW = AW - OB;

    logic [IW-1:0] w_idx;
    logic [DW-1:0] w_rom_dout;
    logic          w_misalign;
    logic          w_oor;
    logic          w_err;
    logic [DW:0]   w_entry;
    logic [DW:0]   w_head;
    logic          w_full;
    logic          w_nonempty;
    logic          w_push;
    logic          w_pop;

    assign w_idx      = rom_icb_cmd_addr[AW-1:OB];
    assign w_misalign = (rom_icb_cmd_addr & AW'((1 << OB) - 1)) != {AW{1'b0}};
    assign w_oor      = (32'(w_idx) >= DP);

    ux607_mrom #(
        .AW (IW),
        .DW (DW)
    ) u_rom (
        .rom_addr (w_idx),
        .rom_dout (w_rom_dout)
    );

    // Build the response entry; any error forces rdata to zero.
    always_comb begin
        w_err = !rom_icb_cmd_read || w_misalign || w_oor;
        if (w_err) begin
            w_entry = {1'b1, {DW{1'b0}}};
        end else begin
            w_entry = {1'b0, w_rom_dout};
        end
    end

    assign w_push = rom_icb_cmd_valid && rom_icb_cmd_ready;
    assign w_pop  = rom_icb_rsp_valid && rom_icb_rsp_ready;

    ux607_mrom_rsp_fifo #(
        .W     (DW + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_entry),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_nonempty  (w_nonempty),
        .o_head      (w_head)
    );

    // ready/valid derive only from buffer state, never from same-cycle inputs
    assign rom_icb_cmd_ready = !w_full;
    assign rom_icb_rsp_valid = w_nonempty;
    assign rom_icb_rsp_err   = w_head[DW];
    assign rom_icb_rsp_rdata = w_head[DW-1:0];
    assign rom_busy          = w_nonempty;

endmodule
